// File: rtl/sram_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_master
// Description : Burst initiator for a single-port synchronous SRAM. It streams
//               write beats in, or read beats out through a 2-entry skid FIFO.
//               Optional address wrap at the top of memory: SRAM_BM_WRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_burst_master #(
  parameter int A_WIDTH = 7,
  parameter int D_WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Cmd_Valid,
  output logic               Cmd_Ready,
  input  logic               Cmd_Write,
  input  logic [A_WIDTH-1:0] Cmd_Addr,
  input  logic [A_WIDTH:0]   Cmd_Len,
  input  logic               Wr_Valid,
  output logic               Wr_Ready,
  input  logic [D_WIDTH-1:0] Wr_Data,
  output logic               Rd_Valid,
  input  logic               Rd_Ready,
  output logic [D_WIDTH-1:0] Rd_Data,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [A_WIDTH-1:0] Sram_Addr,
  output logic               Sram_RW,
  output logic               Sram_En,
  output logic [D_WIDTH-1:0] Sram_Data_In,
  input  logic [D_WIDTH-1:0] Sram_Data_Out
);

  localparam logic [A_WIDTH:0]   c_DEPTH_LEN = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic [A_WIDTH:0]   c_LEN_ONE   = {{A_WIDTH{1'b0}}, 1'b1};
  localparam logic [A_WIDTH-1:0] c_ADDR_ONE  = {{(A_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  state_t             r_state;
  logic [A_WIDTH-1:0] r_addr;
  logic [A_WIDTH:0]   r_remaining;
  logic [A_WIDTH:0]   r_issue_rem;
  logic               r_inflight;
  logic               r_done;
  logic               r_err;

  logic [D_WIDTH-1:0] r_fifo [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;

  logic               w_len_ok;
  logic               w_cmd_legal;
  logic               w_wr_fire;
  logic [1:0]         w_occupancy;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic               w_rd_last;

  assign w_len_ok = (Cmd_Len != '0) && (Cmd_Len <= c_DEPTH_LEN);

`ifdef SRAM_BM_WRAP_EN
  assign w_cmd_legal = w_len_ok;
`else
  localparam logic [A_WIDTH+1:0] c_DEPTH_SPAN = {2'b01, {A_WIDTH{1'b0}}};
  logic [A_WIDTH+1:0] w_span;
  // A burst may end exactly on the last word but never run past it.
  assign w_span      = {2'b00, Cmd_Addr} + {1'b0, Cmd_Len};
  assign w_cmd_legal = w_len_ok && (w_span <= c_DEPTH_SPAN);
`endif

  assign w_wr_fire   = (r_state == S_WRITE) && Wr_Valid;
  // Every issued read owns a FIFO slot, so strict occupancy keeps the FIFO at two entries.
  assign w_occupancy = r_count + {1'b0, r_inflight};
  assign w_issue     = (r_state == S_READ) && (r_issue_rem != '0) && (w_occupancy < 2'd2);
  assign w_push      = r_inflight;
  assign w_pop       = (r_count != 2'd0) && Rd_Ready;
  assign w_rd_last   = (r_state == S_READ) && (r_issue_rem == '0) && !r_inflight &&
                       (r_count == 2'd1) && w_pop;

  assign Cmd_Ready    = (r_state == S_IDLE);
  assign Wr_Ready     = (r_state == S_WRITE);
  assign Busy         = (r_state != S_IDLE);
  assign Done         = r_done;
  assign Err          = r_err;
  assign Rd_Valid     = (r_count != 2'd0);
  assign Rd_Data      = r_fifo[r_rd_ptr];
  assign Sram_En      = w_wr_fire || w_issue;
  assign Sram_RW      = w_wr_fire;
  assign Sram_Addr    = r_addr;
  assign Sram_Data_In = w_wr_fire ? Wr_Data : '0;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_issue_rem <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_inflight <= w_issue;

      case (r_state)
        S_IDLE: begin
          if (Cmd_Valid) begin
            if (w_cmd_legal) begin
              r_addr      <= Cmd_Addr;
              r_remaining <= Cmd_Len;
              r_issue_rem <= Cmd_Len;
              r_state     <= Cmd_Write ? S_WRITE : S_READ;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (Wr_Valid) begin
            r_addr      <= r_addr + c_ADDR_ONE;
            r_remaining <= r_remaining - c_LEN_ONE;
            if (r_remaining == c_LEN_ONE) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_addr      <= r_addr + c_ADDR_ONE;
            r_issue_rem <= r_issue_rem - c_LEN_ONE;
          end
          if (w_rd_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // SRAM read data is only valid in the cycle right after the issue.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= Sram_Data_Out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_burst_master
// Description : Bench for sram_burst_master with a behavioural SRAM and a
//               shadow memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_burst_master;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 2**AW;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          Cmd_Valid = 1'b0;
  logic          Cmd_Ready;
  logic          Cmd_Write = 1'b0;
  logic [AW-1:0] Cmd_Addr = '0;
  logic [AW:0]   Cmd_Len = '0;
  logic          Wr_Valid = 1'b0;
  logic          Wr_Ready;
  logic [DW-1:0] Wr_Data = '0;
  logic          Rd_Valid;
  logic          Rd_Ready = 1'b0;
  logic [DW-1:0] Rd_Data;
  logic          Busy;
  logic          Done;
  logic          Err;
  logic [AW-1:0] Sram_Addr;
  logic          Sram_RW;
  logic          Sram_En;
  logic [DW-1:0] Sram_Data_In;
  logic [DW-1:0] Sram_Data_Out;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] wdata [DEPTH];
  logic [DW-1:0] sram_mem [DEPTH];

  always #5 Clk = ~Clk;

  sram_burst_master #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Write(Cmd_Write),
    .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len),
    .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data),
    .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Rd_Data(Rd_Data),
    .Busy(Busy), .Done(Done), .Err(Err),
    .Sram_Addr(Sram_Addr), .Sram_RW(Sram_RW), .Sram_En(Sram_En),
    .Sram_Data_In(Sram_Data_In), .Sram_Data_Out(Sram_Data_Out)
  );

  // Single-port SRAM: registered read, output zero on any non-read cycle.
  always @(posedge Clk) begin
    if (Sram_En && Sram_RW) sram_mem[Sram_Addr] <= Sram_Data_In;
    Sram_Data_Out <= (Sram_En && !Sram_RW) ? sram_mem[Sram_Addr] : '0;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_cmd(input bit wr, input int addr, input int len);
    logic [31:0] a;
    logic [31:0] l;
    a = addr;
    l = len;
    Cmd_Valid = 1'b1;
    Cmd_Write = wr;
    Cmd_Addr  = a[AW-1:0];
    Cmd_Len   = l[AW:0];
    @(negedge Clk);
    check_eq("cmd_ready", Cmd_Ready, 1);
    check_eq("idle_sram_en", Sram_En, 0);
    next_cycle();
    Cmd_Valid = 1'b0;
  endtask

  task automatic write_burst(input int addr, input int len, input bit hold);
    int beat = 0;
    int cyc  = 0;
    send_cmd(1'b1, addr, len);
    while (beat < len && cyc < 2000) begin
      Wr_Valid = hold ? 1'b1 : ($urandom_range(0, 1) != 0);
      Wr_Data  = wdata[beat];
      @(negedge Clk);
      check_eq("wr_busy", Busy, 1);
      check_eq("wr_ready", Wr_Ready, 1);
      check_eq("wr_done_early", Done, 0);
      if (Wr_Valid) begin
        check_eq("wr_en", Sram_En, 1);
        check_eq("wr_rw", Sram_RW, 1);
        check_eq("wr_addr", Sram_Addr, (addr + beat) % DEPTH);
        check_eq("wr_data", Sram_Data_In, wdata[beat]);
        model_mem[(addr + beat) % DEPTH] = wdata[beat];
        beat++;
      end else begin
        check_eq("wr_idle_en", Sram_En, 0);
      end
      cyc++;
      next_cycle();
    end
    Wr_Valid = 1'b0;
    check_eq("wr_beats", beat, len);
    if (hold) check_eq("wr_busy_cycles", cyc, len);
    @(negedge Clk);
    check_eq("wr_done", Done, 1);
    check_eq("wr_busy_end", Busy, 0);
    next_cycle();
    @(negedge Clk);
    check_eq("wr_done_pulse", Done, 0);
    next_cycle();
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, otherwise random
  task automatic read_burst(input int addr, input int len, input int mode);
    int issued = 0;
    int popped = 0;
    int cyc = 0;
    int first_issue = -1;
    int first_valid = -1;
    send_cmd(1'b0, addr, len);
    while (popped < len && cyc < 2000) begin
      case (mode)
        0:       Rd_Ready = 1'b1;
        1:       Rd_Ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: Rd_Ready = ($urandom_range(0, 1) != 0);
      endcase
      @(negedge Clk);
      check_eq("rd_busy", Busy, 1);
      check_eq("rd_done_early", Done, 0);
      if (Sram_En) begin
        check_eq("rd_rw", Sram_RW, 0);
        check_eq("rd_addr", Sram_Addr, (addr + issued) % DEPTH);
        check_eq("rd_outstanding_lt2", (issued - popped) < 2, 1);
        check_eq("rd_overissue", issued < len, 1);
        if (first_issue < 0) first_issue = cyc;
        issued++;
      end
      if (Rd_Valid && first_valid < 0) first_valid = cyc;
      if (Rd_Valid && Rd_Ready) begin
        check_eq("rd_data", Rd_Data, model_mem[(addr + popped) % DEPTH]);
        popped++;
      end
      cyc++;
      next_cycle();
    end
    Rd_Ready = 1'b0;
    check_eq("rd_beats", popped, len);
    check_eq("rd_issued", issued, len);
    check_eq("rd_latency", first_valid - first_issue, 2);
    @(negedge Clk);
    check_eq("rd_done", Done, 1);
    check_eq("rd_busy_end", Busy, 0);
    check_eq("rd_valid_end", Rd_Valid, 0);
    next_cycle();
    @(negedge Clk);
    check_eq("rd_done_pulse", Done, 0);
    next_cycle();
  endtask

  task automatic err_cmd(input int addr, input int len);
    send_cmd($urandom_range(0, 1) != 0, addr, len);
    @(negedge Clk);
    check_eq("err_pulse", Err, 1);
    check_eq("err_done", Done, 0);
    check_eq("err_busy", Busy, 0);
    check_eq("err_sram_en", Sram_En, 0);
    next_cycle();
    @(negedge Clk);
    check_eq("err_pulse_end", Err, 0);
    check_eq("err_sram_en2", Sram_En, 0);
    next_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, Busy, 0);
    check_eq({tag, "_done"}, Done, 0);
    check_eq({tag, "_err"}, Err, 0);
    check_eq({tag, "_en"}, Sram_En, 0);
    check_eq({tag, "_rw"}, Sram_RW, 0);
    check_eq({tag, "_addr"}, Sram_Addr, 0);
    check_eq({tag, "_din"}, Sram_Data_In, 0);
    check_eq({tag, "_rvalid"}, Rd_Valid, 0);
    check_eq({tag, "_cmd_ready"}, Cmd_Ready, 1);
    check_eq({tag, "_wr_ready"}, Wr_Ready, 0);
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    @(negedge Clk);
    check_reset_outputs("reset");
    next_cycle();
    Rst = 1'b0;

    // Fill the whole memory with one maximum-length burst.
    for (int i = 0; i < DEPTH; i++) wdata[i] = $urandom;
    write_burst(0, DEPTH, 1'b0);

    wdata[0] = 32'hA0; wdata[1] = 32'hA1; wdata[2] = 32'hA2;
    write_burst(5, 3, 1'b1);
    read_burst(5, 3, 0);

    for (int i = 0; i < 8; i++) wdata[i] = $urandom;
    write_burst(20, 8, 1'b1);
    read_burst(20, 8, 1);

    err_cmd(10, 0);

    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    write_burst(124, 4, 1'b0);
    read_burst(124, 4, 2);
`ifdef SRAM_BM_WRAP_EN
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    write_burst(126, 4, 1'b1);
    read_burst(126, 4, 0);
`else
    err_cmd(126, 4);
`endif

    // Reset lands on the second beat of a four-beat write.
    for (int i = 0; i < 4; i++) wdata[i] = $urandom;
    send_cmd(1'b1, 40, 4);
    Wr_Valid = 1'b1;
    Wr_Data  = wdata[0];
    @(negedge Clk);
    check_eq("rst_first_addr", Sram_Addr, 40);
    model_mem[40] = wdata[0];
    next_cycle();
    Wr_Data = wdata[1];
    Rst     = 1'b1;
    next_cycle();
    Rst      = 1'b0;
    Wr_Valid = 1'b0;
    @(negedge Clk);
    check_reset_outputs("midrst");
    next_cycle();
    @(negedge Clk);
    check_eq("midrst_no_done", Done, 0);
    next_cycle();
    read_burst(40, 1, 0);
    wdata[0] = $urandom;
    write_burst(41, 1, 1'b1);

    for (int t = 0; t < 25; t++) begin
      int a;
      int l;
      bit wr;
      bit legal;
      a  = $urandom_range(0, DEPTH - 1);
      l  = $urandom_range(1, 16);
      wr = ($urandom_range(0, 1) != 0);
`ifdef SRAM_BM_WRAP_EN
      legal = 1'b1;
`else
      legal = (a + l) <= DEPTH;
`endif
      if (!legal) begin
        err_cmd(a, l);
      end else if (wr) begin
        for (int i = 0; i < l; i++) wdata[i] = $urandom;
        write_burst(a, l, 1'b0);
      end else begin
        read_burst(a, l, 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
